// File: rtl/hdc_pkg.sv
// Shared definitions for the hyperdimensional class-query datapath.
package hdc_pkg;

    localparam int HV_DIM      = 10;
    localparam int NUM_CLASSES = 26;
    localparam int CLASS_W     = 5;
    localparam int SCORE_W     = 4;
    localparam int CLASSES_W   = HV_DIM * NUM_CLASSES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/class_query_if.sv
// Request/result bundle between a query producer and the class_query engine.
interface class_query_if;
    import hdc_pkg::*;

    logic                   start;
    logic [HV_DIM-1:0]      query;
    logic [CLASSES_W-1:0]   class_hv_flat;
    logic                   out_ready;
    logic                   busy;
    logic                   out_valid;
    logic [CLASS_W-1:0]     class_out;
    logic [SCORE_W-1:0]     score;
    logic                   no_match;

    // Producer / consumer side.
    modport master (
        output start, query, class_hv_flat, out_ready,
        input  busy, out_valid, class_out, score, no_match
    );

    // Engine side.
    modport slave (
        input  start, query, class_hv_flat, out_ready,
        output busy, out_valid, class_out, score, no_match
    );

endinterface

// File: rtl/hv_popcount.sv
// Combinational population count of one hypervector.
module hv_popcount
    import hdc_pkg::*;
(
    input  logic [HV_DIM-1:0]  vec_i,
    output logic [SCORE_W-1:0] count_o
);

    // Sum the set bits of the vector.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            count_o = count_o + SCORE_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/class_query.sv
// Sequential best-match search of a query hypervector against 26 class
// hypervectors, one class per cycle, with a registered valid/ready result.
module class_query
    import hdc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    class_query_if.slave  bus
);

    state_e               state_q, state_d;
    logic [HV_DIM-1:0]    query_q, query_d;
    logic [CLASS_W-1:0]   idx_q, idx_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [CLASS_W-1:0]   best_idx_q, best_idx_d;
    logic                 busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 no_match_q, no_match_d;

    logic [HV_DIM-1:0]    class_hv;
    logic [SCORE_W-1:0]   overlap;
    logic                 better;
    logic [SCORE_W-1:0]   cand_score;
    logic [CLASS_W-1:0]   cand_idx;

    assign class_hv = bus.class_hv_flat[int'(idx_q) * HV_DIM +: HV_DIM];

    hv_popcount u_popcount (
        .vec_i   (query_q & class_hv),
        .count_o (overlap)
    );

    // Strict compare keeps the lowest index on ties; the candidate pair also
    // feeds the result registers on the final scan cycle.
    assign better     = overlap > best_score_q;
    assign cand_score = better ? overlap : best_score_q;
    assign cand_idx   = better ? idx_q   : best_idx_q;

    // State and datapath registers; reset clears everything, including the
    // captured query, so an interrupted search leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            query_q      <= '0;
            idx_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            class_q      <= '0;
            score_q      <= '0;
            no_match_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            query_q      <= query_d;
            idx_q        <= idx_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            class_q      <= class_d;
            score_q      <= score_d;
            no_match_q   <= no_match_d;
        end
    end

    // Next-state logic: accept in IDLE, scan 26 classes, hold result in DONE.
    always_comb begin
        state_d      = state_q;
        query_d      = query_q;
        idx_d        = idx_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        class_d      = class_q;
        score_d      = score_q;
        no_match_d   = no_match_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_SCAN;
                    query_d      = bus.query;
                    idx_d        = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    busy_d       = 1'b1;
                end
            end
            S_SCAN: begin
                best_score_d = cand_score;
                best_idx_d   = cand_idx;
                if (idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    class_d     = cand_idx;
                    score_d     = cand_score;
                    no_match_d  = (cand_score == '0);
                end else begin
                    idx_d = idx_q + CLASS_W'(1);
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here: no queuing.
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.class_out = class_q;
    assign bus.score     = score_q;
    assign bus.no_match  = no_match_q;

endmodule
